// File: rtl/sounder_pn_tx.sv
// PN-sequence transmit source: maximal-length LFSR (degree 7..16) clocked at a
// programmable chip rate. Each chip is BPSK-mapped to +/-amplitude on I and Q,
// and a one-cycle marker flags the first chip of every sequence period.
module sounder_pn_tx #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [4:0]       degree_i,
  input  logic [12:0]      amplitude_i,
  input  logic [DIV_W-1:0] chip_div_i,
  output logic [WIDTH-1:0] tx_i_o,
  output logic [WIDTH-1:0] tx_q_o,
  output logic             strobe_o,
  output logic             seq_start_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       deg_q, deg_d;
  logic [12:0]      amp_q, amp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [15:0]      chip_q, chip_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] tx_i_q, tx_i_d;
  logic [WIDTH-1:0] tx_q_q, tx_q_d;
  logic             strobe_q, strobe_d;
  logic             seq_q, seq_d;

  function automatic logic [4:0] clamp_deg(input logic [4:0] d);
    if (d < 5'd7)       return 5'd7;
    else if (d > 5'd16) return 5'd16;
    else                return d;
  endfunction

  // Low 'd' bits set: the all-ones LFSR seed for degree d.
  function automatic logic [15:0] ones_mask(input logic [4:0] d);
    logic [16:0] m;
    m = (17'd1 << d) - 17'd1;
    return m[15:0];
  endfunction

  // Index of the last chip of a period: 2^d - 2.
  function automatic logic [15:0] chip_last(input logic [4:0] d);
    logic [16:0] m;
    m = (17'd1 << d) - 17'd2;
    return m[15:0];
  endfunction

  // Fibonacci step toward bit 0. Stage t (1..d) counted from the input end
  // sits at bit d-t, so tap t reads bit d-t and the sum re-enters at bit d-1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input logic [4:0] d);
    logic fb;
    case (d)
      5'd8:    fb = s[0] ^ s[2] ^ s[3] ^ s[4];
      5'd9:    fb = s[0] ^ s[4];
      5'd10:   fb = s[0] ^ s[3];
      5'd11:   fb = s[0] ^ s[2];
      5'd12:   fb = s[0] ^ s[1] ^ s[2] ^ s[8];
      5'd13:   fb = s[0] ^ s[1] ^ s[2] ^ s[5];
      5'd14:   fb = s[0] ^ s[1] ^ s[2] ^ s[12];
      5'd15:   fb = s[0] ^ s[1];
      5'd16:   fb = s[0] ^ s[1] ^ s[3] ^ s[12];
      default: fb = s[0] ^ s[1];
    endcase
    return ((s >> 1) & ones_mask(d)) | (16'(fb) << (d - 5'd1));
  endfunction

  function automatic logic [WIDTH-1:0] chip_val(input logic b, input logic [12:0] a);
    logic [WIDTH-1:0] ext;
    ext = {{(WIDTH-13){1'b0}}, a};
    return b ? ext : (~ext + 1'b1);
  endfunction

  // State and datapath registers; reset clears outputs and seeds the LFSR.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      deg_q    <= 5'd7;
      amp_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      chip_q   <= '0;
      lfsr_q   <= '1;
      tx_i_q   <= '0;
      tx_q_q   <= '0;
      strobe_q <= 1'b0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      deg_q    <= deg_d;
      amp_q    <= amp_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      chip_q   <= chip_d;
      lfsr_q   <= lfsr_d;
      tx_i_q   <= tx_i_d;
      tx_q_q   <= tx_q_d;
      strobe_q <= strobe_d;
      seq_q    <= seq_d;
    end
  end

  // Next-state: enable handling, chip-rate divider, period tracking, mapping.
  always_comb begin
    state_d  = state_q;
    deg_d    = deg_q;
    amp_d    = amp_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    chip_d   = chip_q;
    lfsr_d   = lfsr_q;
    tx_i_d   = tx_i_q;
    tx_q_d   = tx_q_q;
    strobe_d = 1'b0;
    seq_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena_i) begin
          state_d = RUN;
          deg_d   = clamp_deg(degree_i);
          amp_d   = amplitude_i;
          div_d   = chip_div_i;
          cnt_d   = '0;
          chip_d  = '0;
          lfsr_d  = ones_mask(clamp_deg(degree_i));
        end
      end
      RUN: begin
        if (!ena_i) begin
          // Disable takes priority over a pending strobe.
          state_d = IDLE;
          cnt_d   = '0;
          chip_d  = '0;
          lfsr_d  = '1;
          tx_i_d  = '0;
          tx_q_d  = '0;
        end else if (cnt_q == div_q) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          // Chips are mapped from the pre-advance LFSR with the current amp_q.
          tx_i_d   = chip_val(lfsr_q[0], amp_q);
          tx_q_d   = chip_val(lfsr_q[1], amp_q);
          if (chip_q == '0) begin
            seq_d = 1'b1;
            deg_d = clamp_deg(degree_i);
            amp_d = amplitude_i;
            div_d = chip_div_i;
          end
          if (chip_q == chip_last(deg_q)) begin
            chip_d = '0;
            lfsr_d = ones_mask(deg_q);
          end else begin
            chip_d = chip_q + 16'd1;
            lfsr_d = lfsr_next(lfsr_q, deg_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_i_o      = tx_i_q;
  assign tx_q_o      = tx_q_q;
  assign strobe_o    = strobe_q;
  assign seq_start_o = seq_q;

endmodule

// File: tb/tb_sounder_pn_tx.sv
// Scoreboard bench for sounder_pn_tx: the stimulus process pushes the expected
// chip stream (from a software LFSR model) and a negedge monitor pops one entry
// per strobe, also checking idle zeros and sample hold between strobes.
module tb_sounder_pn_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [4:0]  degree = 5'd7;
  logic [12:0] amplitude = '0;
  logic [7:0]  chip_div = '0;
  logic [13:0] tx_i, tx_q;
  logic        strobe, seq_start;

  sounder_pn_tx #(.WIDTH(14), .DIV_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .ena_i       (ena),
    .degree_i    (degree),
    .amplitude_i (amplitude),
    .chip_div_i  (chip_div),
    .tx_i_o      (tx_i),
    .tx_q_o      (tx_q),
    .strobe_o    (strobe),
    .seq_start_o (seq_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] i;
    logic [13:0] q;
    logic        ss;
    int          gap;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feedback of the reference LFSR: tap t of degree d reads stage t, i.e. bit d-t.
  function automatic int fbk(input int s, input int d);
    int t[4];
    int f;
    case (d)
      8:       t = '{8, 6, 5, 4};
      9:       t = '{9, 5, 0, 0};
      10:      t = '{10, 7, 0, 0};
      11:      t = '{11, 9, 0, 0};
      12:      t = '{12, 11, 10, 4};
      13:      t = '{13, 12, 11, 8};
      14:      t = '{14, 13, 12, 2};
      15:      t = '{15, 14, 0, 0};
      16:      t = '{16, 15, 13, 4};
      default: t = '{7, 6, 0, 0};
    endcase
    f = 0;
    for (int j = 0; j < 4; j++)
      if (t[j] != 0) f ^= (s >> (d - t[j])) & 1;
    return f;
  endfunction

  // Push n expected chips; amplitude a1 applies from chip 1 of the second period.
  task automatic push_chips(input int d, input int a0, input int a1, input int dv, input int n);
    int p, s, amp;
    exp_t e;
    logic [13:0] a;
    p = (1 << d) - 1;
    s = p;
    for (int c = 0; c < n; c++) begin
      amp  = (c > p) ? a1 : a0;
      a    = 14'(amp);
      e.i  = s[0] ? a : 14'd0 - a;
      e.q  = s[1] ? a : 14'd0 - a;
      e.ss = ((c % p) == 0);
      e.gap = dv + 1;
      sbq.push_back(e);
      if ((c % p) == p - 1) s = p;
      else s = (s >> 1) | (fbk(s, d) << (d - 1));
    end
  endtask

  // Called just after a posedge. Runs n chips then drops enable right after the
  // last strobe edge, leaving a few idle cycles.
  task automatic run_seg(input int deg_in, input int deg_eff, input int amp_in, input int amp_new,
                         input int chg_after, input int dv, input int n);
    degree    = 5'(deg_in);
    amplitude = 13'(amp_in);
    chip_div  = 8'(dv);
    push_chips(deg_eff, amp_in, amp_new, dv, n);
    ena = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= n * (dv + 1); cyc++) begin
      @(posedge clk); #1;
      if (cyc == dv + 1) begin
        chk("first_i", 32'(tx_i), 32'(14'(amp_in)));
        chk("first_q", 32'(tx_q), 32'(14'(amp_in)));
        chk("first_seq", 32'(seq_start), 32'd1);
      end
      if (cyc == chg_after) amplitude = 13'(amp_new);
    end
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("leftover", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Monitor: sampled on negedge, away from the active edge.
  logic ena_prev = 1'b0;
  int   gap = -1;
  logic [13:0] last_i = '0, last_q = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !ena_prev) begin
      chk("idle_i", 32'(tx_i), 32'd0);
      chk("idle_q", 32'(tx_q), 32'd0);
      chk("idle_strobe", 32'(strobe), 32'd0);
      chk("idle_seq", 32'(seq_start), 32'd0);
      gap = -1;
      last_i = '0;
      last_q = '0;
    end else begin
      gap++;
      if (strobe) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("tx_i", 32'(tx_i), 32'(e.i));
          chk("tx_q", 32'(tx_q), 32'(e.q));
          chk("seq_start", 32'(seq_start), 32'(e.ss));
          chk("strobe_gap", 32'(gap), 32'(e.gap));
          last_i = e.i;
          last_q = e.q;
        end
        gap = 0;
      end else begin
        chk("hold_i", 32'(tx_i), 32'(last_i));
        chk("hold_q", 32'(tx_q), 32'(last_q));
        chk("hold_seq", 32'(seq_start), 32'd0);
      end
    end
    ena_prev = ena;
  end

  initial begin
    #1;
    chk("rst_i", 32'(tx_i), 32'd0);
    chk("rst_q", 32'(tx_q), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_seq", 32'(seq_start), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // deg 7, strobe every cycle, three full periods
    run_seg(7, 7, 1000, 1000, -1, 0, 381);
    // chip divider 3: strobe every 4th cycle, hold in between
    run_seg(8, 8, 300, 300, -1, 3, 20);
    // degree below range clamps to 7
    run_seg(4, 7, 1234, 1234, -1, 1, 130);
    // amplitude change mid-period takes effect at the next period
    run_seg(7, 7, 1000, 8191, 40, 0, 259);
    // disable mid-period, then re-enable replays from chip 0
    run_seg(9, 9, 777, 777, -1, 1, 30);
    run_seg(9, 9, 777, 777, -1, 1, 40);

    // asynchronous reset between edges during a run
    degree = 5'd7; amplitude = 13'd1000; chip_div = 8'd0;
    push_chips(7, 1000, 1000, 0, 200);
    ena = 1'b1;
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_i", 32'(tx_i), 32'd0);
    chk("async_rst_q", 32'(tx_q), 32'd0);
    chk("async_rst_strobe", 32'(strobe), 32'd0);
    ena = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_seg(7, 7, 1000, 1000, -1, 0, 20);

    // degree above range clamps to 16: full 65535-chip period plus wrap
    run_seg(20, 16, 500, 500, -1, 0, 65537);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
